// File: rtl/cnn_layer2_seq_ctrl.sv
// cnn_layer2_seq_ctrl: layer-2 conv/pool sequencer.
// Streams one weight image into the W1/W2/bias RAMs, then steps the output phases.
//
// Ports:
//   CLK, RSTn        clock (rising edge), async active-low reset
//   START, SKIP_LOAD run request (sampled in IDLE), reuse loaded weights
//   CFG_VALID/READY  config beat handshake, CFG_DATA word (W1, W2, B order)
//   CONV_*_WEN       1-cycle RAM write strobes, registered
//   CONV_W_ADDR      shared write address, CONV_WDATA shared write data
//   PHASE_SEL        current output channel to the core
//   DIN_EN           upstream pixel feeder gate
//   CORE_LAST_PIX    end of the current phase, from the core
//   BUSY, DONE       run in progress, 1-cycle completion pulse

module cnn_layer2_seq_ctrl #(
  parameter int DW         = 24,
  parameter int W1_DEPTH   = 150,
  parameter int W2_DEPTH   = 150,
  parameter int B_DEPTH    = 6,
  parameter int NUM_PHASES = 6,
  parameter int FLUSH_CYC  = 4
) (
  input  logic          CLK,
  input  logic          RSTn,
  input  logic          START,
  input  logic          SKIP_LOAD,
  input  logic          CFG_VALID,
  output logic          CFG_READY,
  input  logic [DW-1:0] CFG_DATA,
  output logic          CONV_W1_WEN,
  output logic          CONV_W2_WEN,
  output logic          CONV_B_WEN,
  output logic [7:0]    CONV_W_ADDR,
  output logic [DW-1:0] CONV_WDATA,
  output logic [2:0]    PHASE_SEL,
  output logic          DIN_EN,
  input  logic          CORE_LAST_PIX,
  output logic          BUSY,
  output logic          DONE
);

  localparam logic [7:0] W1_LAST = 8'(W1_DEPTH - 1);
  localparam logic [7:0] W2_LAST = 8'(W2_DEPTH - 1);
  localparam logic [7:0] B_LAST  = 8'(B_DEPTH - 1);
  localparam logic [7:0] FL_LAST = 8'(FLUSH_CYC - 1);
  localparam logic [2:0] PH_LAST = 3'(NUM_PHASES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LD_W1,
    S_LD_W2,
    S_LD_B,
    S_RUN,
    S_FLUSH,
    S_FIN
  } state_e;

  state_e        state_q, state_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [7:0]    fcnt_q, fcnt_d;
  logic [2:0]    phase_q, phase_d;
  logic [7:0]    addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          w1_wen_q, w1_wen_d;
  logic          w2_wen_q, w2_wen_d;
  logic          b_wen_q, b_wen_d;
  logic          din_en_q, din_en_d;
  logic          ld;
  logic          acc;

  assign ld  = (state_q == S_LD_W1) ||
               (state_q == S_LD_W2) ||
               (state_q == S_LD_B);
  assign acc = ld && CFG_VALID;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    fcnt_d   = fcnt_q;
    phase_d  = phase_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    w1_wen_d = 1'b0;
    w2_wen_d = 1'b0;
    b_wen_d  = 1'b0;
    // Gate opens one cycle after RUN entry, closes the cycle after LAST_PIX.
    din_en_d = (state_q == S_RUN) && !CORE_LAST_PIX;

    // Every accepted beat captures address and data; strobe chosen below.
    if (acc) begin
      addr_d  = cnt_q;
      wdata_d = CFG_DATA;
      cnt_d   = cnt_q + 8'd1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (START) begin
          if (SKIP_LOAD) begin
            state_d = S_RUN;
            phase_d = 3'd0;
          end else begin
            state_d = S_LD_W1;
            cnt_d   = 8'd0;
          end
        end
      end
      S_LD_W1: begin
        if (acc) begin
          w1_wen_d = 1'b1;
          if (cnt_q == W1_LAST) begin
            state_d = S_LD_W2;
            cnt_d   = 8'd0;
          end
        end
      end
      S_LD_W2: begin
        if (acc) begin
          w2_wen_d = 1'b1;
          if (cnt_q == W2_LAST) begin
            state_d = S_LD_B;
            cnt_d   = 8'd0;
          end
        end
      end
      S_LD_B: begin
        if (acc) begin
          b_wen_d = 1'b1;
          if (cnt_q == B_LAST) begin
            state_d = S_RUN;
            cnt_d   = 8'd0;
            phase_d = 3'd0;
          end
        end
      end
      S_RUN: begin
        if (CORE_LAST_PIX) begin
          if (phase_q == PH_LAST) begin
            state_d = S_FIN;
          end else begin
            state_d = S_FLUSH;
            fcnt_d  = 8'd0;
          end
        end
      end
      S_FLUSH: begin
        fcnt_d = fcnt_q + 8'd1;
        // Phase advances while the gate is still closed.
        if (fcnt_q == FL_LAST) begin
          phase_d = phase_q + 3'd1;
          state_d = S_RUN;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q  <= S_IDLE;
      cnt_q    <= 8'd0;
      fcnt_q   <= 8'd0;
      phase_q  <= 3'd0;
      addr_q   <= 8'd0;
      wdata_q  <= '0;
      w1_wen_q <= 1'b0;
      w2_wen_q <= 1'b0;
      b_wen_q  <= 1'b0;
      din_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      fcnt_q   <= fcnt_d;
      phase_q  <= phase_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      w1_wen_q <= w1_wen_d;
      w2_wen_q <= w2_wen_d;
      b_wen_q  <= b_wen_d;
      din_en_q <= din_en_d;
    end
  end

  assign CFG_READY   = ld;
  assign CONV_W1_WEN = w1_wen_q;
  assign CONV_W2_WEN = w2_wen_q;
  assign CONV_B_WEN  = b_wen_q;
  assign CONV_W_ADDR = addr_q;
  assign CONV_WDATA  = wdata_q;
  assign PHASE_SEL   = phase_q;
  assign DIN_EN      = din_en_q;
  assign BUSY        = (state_q != S_IDLE);
  assign DONE        = (state_q == S_FIN);

endmodule

// File: tb/tb_cnn_layer2_seq_ctrl.sv
// tb_cnn_layer2_seq_ctrl: randomized bench for the layer-2 sequencer.
// Beat-count write model plus phase/flush timing model.

module tb_cnn_layer2_seq_ctrl;

  localparam int DW    = 24;
  localparam int W1D   = 150;
  localparam int W2D   = 150;
  localparam int BD    = 6;
  localparam int NP    = 6;
  localparam int FC    = 4;
  localparam int TOTAL = W1D + W2D + BD;

  logic          CLK;
  logic          RSTn;
  logic          START;
  logic          SKIP_LOAD;
  logic          CFG_VALID;
  logic          CFG_READY;
  logic [DW-1:0] CFG_DATA;
  logic          CONV_W1_WEN;
  logic          CONV_W2_WEN;
  logic          CONV_B_WEN;
  logic [7:0]    CONV_W_ADDR;
  logic [DW-1:0] CONV_WDATA;
  logic [2:0]    PHASE_SEL;
  logic          DIN_EN;
  logic          CORE_LAST_PIX;
  logic          BUSY;
  logic          DONE;

  logic [2:0]    wens;
  assign wens = {CONV_W1_WEN, CONV_W2_WEN, CONV_B_WEN};

  int            n_chk;
  int            n_fail;
  logic [7:0]    m_addr;
  logic [DW-1:0] m_data;
  bit            ab;

  cnn_layer2_seq_ctrl #(
    .DW(DW), .W1_DEPTH(W1D), .W2_DEPTH(W2D),
    .B_DEPTH(BD), .NUM_PHASES(NP), .FLUSH_CYC(FC)
  ) dut (
    .CLK(CLK),
    .RSTn(RSTn),
    .START(START),
    .SKIP_LOAD(SKIP_LOAD),
    .CFG_VALID(CFG_VALID),
    .CFG_READY(CFG_READY),
    .CFG_DATA(CFG_DATA),
    .CONV_W1_WEN(CONV_W1_WEN),
    .CONV_W2_WEN(CONV_W2_WEN),
    .CONV_B_WEN(CONV_B_WEN),
    .CONV_W_ADDR(CONV_W_ADDR),
    .CONV_WDATA(CONV_WDATA),
    .PHASE_SEL(PHASE_SEL),
    .DIN_EN(DIN_EN),
    .CORE_LAST_PIX(CORE_LAST_PIX),
    .BUSY(BUSY),
    .DONE(DONE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h (t=%0t)",
               tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_rdy"}, CFG_READY, 0);
    chk({tag, "_wen"}, wens, 0);
    chk({tag, "_addr"}, CONV_W_ADDR, 0);
    chk({tag, "_data"}, CONV_WDATA, 0);
    chk({tag, "_ph"}, PHASE_SEL, 0);
    chk({tag, "_din"}, DIN_EN, 0);
    chk({tag, "_busy"}, BUSY, 0);
    chk({tag, "_done"}, DONE, 0);
  endtask

  // Beat n of the image lands in W1, then W2, then bias.
  task automatic beat_target(input int n,
                             output logic [2:0] w,
                             output logic [7:0] a);
    if (n < W1D) begin
      w = 3'b100; a = 8'(n);
    end else if (n < W1D + W2D) begin
      w = 3'b010; a = 8'(n - W1D);
    end else begin
      w = 3'b001; a = 8'(n - W1D - W2D);
    end
  endtask

  task automatic load(input int gap, input int abort_at,
                      output bit aborted);
    int n;
    int cyc;
    bit v;
    logic [DW-1:0] d;
    logic [2:0] ew;
    logic [7:0] ea;
    aborted = 0;
    START = 1; SKIP_LOAD = 0;
    CFG_VALID = 1; CFG_DATA = DW'($urandom);
    tick();
    START = 0;
    chk("ld_busy", BUSY, 1);
    chk("ld_idle_wen", wens, 0);
    chk("ld_idle_addr", CONV_W_ADDR, m_addr);
    chk("ld_idle_data", CONV_WDATA, m_data);
    n = 0;
    cyc = 0;
    while (n < TOTAL && cyc < 5000) begin
      v = ($urandom_range(99) >= gap);
      d = DW'($urandom);
      CFG_VALID = v;
      CFG_DATA = d;
      chk("ld_rdy", CFG_READY, 1);
      tick();
      cyc++;
      ew = 3'b000;
      if (v) begin
        beat_target(n, ew, ea);
        m_addr = ea;
        m_data = d;
        n++;
      end
      chk("ld_wen", wens, ew);
      chk("ld_addr", CONV_W_ADDR, m_addr);
      chk("ld_data", CONV_WDATA, m_data);
      chk("ld_din", DIN_EN, 0);
      if (abort_at >= 0 && n == abort_at) begin
        aborted = 1;
        return;
      end
    end
    chk("ld_count", n, TOTAL);
    CFG_VALID = 0;
    chk("ld_end_rdy", CFG_READY, 0);
    chk("ld_end_busy", BUSY, 1);
  endtask

  task automatic spur_inputs(input bit spur);
    if (spur) begin
      START = 1'($urandom_range(1));
      SKIP_LOAD = 1'($urandom_range(1));
      CFG_VALID = 1'($urandom_range(1));
      CFG_DATA = DW'($urandom);
    end else begin
      START = 0;
      CFG_VALID = 0;
    end
  endtask

  // Entry: the sample just taken is the first RUN cycle of phase 0.
  task automatic run_phases(input int lmin, input int lmax, input bit spur);
    int len;
    int low;
    low = 0;
    chk("run0_din", DIN_EN, 0);
    chk("run0_ph", PHASE_SEL, 0);
    chk("run0_busy", BUSY, 1);
    for (int p = 0; p < NP; p++) begin
      len = $urandom_range(lmax, lmin);
      for (int j = 0; j < len; j++) begin
        spur_inputs(spur);
        CORE_LAST_PIX = (j == len - 1);
        tick();
        chk("run_din", DIN_EN, (j != len - 1));
        chk("run_ph", PHASE_SEL, p);
        chk("run_wen", wens, 0);
        chk("run_rdy", CFG_READY, 0);
        if (j == 0 && p > 0)
          chk("flush_gap", low, FC + 1);
        if (j != len - 1 || p != NP - 1)
          chk("run_done", DONE, 0);
      end
      if (p < NP - 1) begin
        low = (DIN_EN == 0) ? 1 : 0;
        for (int k = 2; k <= FC + 1; k++) begin
          spur_inputs(spur);
          CORE_LAST_PIX = spur ? 1'($urandom_range(1)) : 1'b0;
          tick();
          if (!DIN_EN) low++;
          chk("flush_ph", PHASE_SEL, (k == FC + 1) ? p + 1 : p);
          chk("flush_busy", BUSY, 1);
          chk("flush_wen", wens, 0);
        end
        CORE_LAST_PIX = 0;
      end
    end
    chk("fin_done", DONE, 1);
    chk("fin_busy", BUSY, 1);
    chk("fin_din", DIN_EN, 0);
    // START in the DONE cycle must be ignored.
    START = 1; SKIP_LOAD = 1;
    CFG_VALID = 0; CORE_LAST_PIX = 0;
    tick();
    START = 0; SKIP_LOAD = 0;
    chk("post_done", DONE, 0);
    chk("post_busy", BUSY, 0);
    chk("post_din", DIN_EN, 0);
  endtask

  task automatic skip_start();
    START = 1; SKIP_LOAD = 1;
    CFG_VALID = 1; CFG_DATA = DW'($urandom);
    tick();
    START = 0; SKIP_LOAD = 0; CFG_VALID = 0;
    chk("skip_busy", BUSY, 1);
    chk("skip_wen", wens, 0);
    chk("skip_rdy", CFG_READY, 0);
  endtask

  task automatic mid_reset();
    #2;
    RSTn = 0;
    #1;
    chk_zero("async_rst");
    START = 1;
    CFG_VALID = 1;
    tick();
    tick();
    chk_zero("held_rst");
    RSTn = 1;
    START = 0;
    CFG_VALID = 0;
    m_addr = 0;
    m_data = 0;
    tick();
    chk_zero("post_rst");
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    m_addr = 0;
    m_data = 0;
    RSTn = 0;
    START = 0;
    SKIP_LOAD = 0;
    CFG_VALID = 0;
    CFG_DATA = 0;
    CORE_LAST_PIX = 0;
    tick();
    chk_zero("reset");
    tick();
    RSTn = 1;
    for (int i = 0; i < 8; i++) begin
      CFG_VALID = 1;
      CFG_DATA = DW'($urandom);
      CORE_LAST_PIX = 1'($urandom_range(1));
      tick();
      chk_zero("idle");
    end
    CFG_VALID = 0;
    CORE_LAST_PIX = 0;

    load(0, -1, ab);
    run_phases(100, 100, 0);

    skip_start();
    run_phases(2, 12, 1);

    load(30, -1, ab);
    run_phases(2, 30, 1);

    load(0, W1D + 40, ab);
    chk("abort_hit", ab, 1);
    mid_reset();
    load(0, -1, ab);
    run_phases(2, 8, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
